controlador_somador_serial: RTL and testbench
=============================================

Name: controlador_somador_serial

Overview:
- Bit-serial add/subtract sequencer for the ALU (ULA).
- Drives one 1-bit adder/subtractor slice over WIDTH clock cycles instead of a WIDTH-slice ripple chain.
- Registers the slice's carry and two's-complement chain signals between cycles, shifts operands LSB-first and assembles the result.
- Start/done handshake toward the ALU control logic.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- sub  in  1  0 = A+B, 1 = A-B (two's complement); sampled together with start.
- op_a  in  WIDTH  operand A (signed); sampled with start.
- op_b  in  WIDTH  operand B (signed); sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result and overflow valid.
- result  out  WIDTH  sum/difference modulo 2^WIDTH; held until the next accepted start.
- overflow  out  1  signed overflow of the last operation; held like result.

Behaviour:
- Reset: rst high at an edge forces state OCIOSO, bit counter 0, carry_q 0, comp_q 1. Outputs busy 0, done 0, result 0, overflow 0. rst has priority over start.
- States:
  - OCIOSO (idle).
  - CALC (busy=1).
  - FIM (done=1 for exactly one cycle).
- Accept: start=1 at an edge while in OCIOSO or FIM.
  - Latch op_a, op_b and sub; counter cleared; carry_q=0, comp_q=1; go to CALC.
  - result and overflow keep their old values until completion.
- CALC, one bit per edge:
  - Slice gets A=a_sh[0], B=b_sh[0], Cin=carry_q, COMPLEMENTOin=comp_q, select=sub_q.
  - Slice R is shifted into the result register from the MSB side.
  - carry_q and comp_q take the slice's Cout and COMPLEMENTOout.
  - a_sh and b_sh shift right by 1; counter increments.
- CALC exit: the edge that processes bit WIDTH-1 moves to FIM.
  - result and overflow update on that same edge.
  - Start sampled at edge k gives done=1 during the cycle after edge k+WIDTH (latency WIDTH edges).
- FIM:
  - Without start, the next edge returns to OCIOSO.
  - With start, the next edge accepts the new operation (back-to-back, no idle bubble).
- start while in CALC is ignored: no re-latch, no queueing.
- Overflow uses original operand MSBs and the result MSB:
  - Add: overflow = (a_msb == b_msb) && (r_msb != a_msb).
  - Sub: overflow = (a_msb != b_msb) && (r_msb != a_msb).
- Wrap-around: result is always modulo 2^WIDTH, including on overflow. Subtracting the most negative value wraps per two's complement and flags overflow when a_msb=0.
- rst during CALC: operation abandoned, no done pulse; OCIOSO from the next cycle.
- sub, op_a and op_b are don't-care outside the accept edge.

Optional Feature:
- Macro: SOMADOR_SERIAL_ZERO_FLAG_EN.
- Defined: extra output port zero (1 bit). Registered on the completion edge as (result == 0), held with result; reset value 0.
- Undefined: port absent; no extra logic.

Decomposition:
- Package somador_serial_pkg:
  - State encodings OCIOSO=2'b00, CALC=2'b01, FIM=2'b10.
  - Counter-width function (clog2 of WIDTH).
  - Reset constants for carry_q (0) and comp_q (1).
- Sub-module: exactly one instance of the existing CircuitoSomador 1-bit slice. The controller adds no arithmetic beyond the overflow and zero compare.

Test Plan (WIDTH=3):
- Reset: rst high 2 cycles with start=1 -> busy 0, done 0, result 3'b000, overflow 0; no operation accepted.
- Add: op_a=3'b011 (3), op_b=3'b110 (-2), sub=0, start pulse -> busy 3 cycles, done after 3rd edge, result 3'b001, overflow 0.
- Sub overflow: op_a=3'b000, op_b=3'b100 (-4), sub=1 -> result 3'b100, overflow 1. Then 2-3 -> result 3'b111 (-1), overflow 0.
- Handshake:
  - start held high during CALC with op_a=3'b111 -> ignored; first result unchanged.
  - start in the FIM cycle -> accepted; next done exactly 3 edges later.
- Reset mid-op: rst for one edge during the 2nd CALC cycle -> no done pulse; idle next cycle; result keeps its pre-op value 3'b000.
- Exhaustive: both sub values x 64 operand pairs, back-to-back -> result == (A±B) mod 8 and overflow matches the sign rule; zero flag checked when the macro is defined.

Source files
------------

// File: rtl/somador_serial_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package somador_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

  localparam logic CARRY_RST = 1'b0;
  localparam logic COMP_RST  = 1'b1;

  // Bits needed to count 0..w-1 (clog2 of w, at least 1).
  function automatic int cnt_width(input int w);
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < w) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/circuito_somador.sv
// 1-bit adder/subtractor slice. For subtraction B is negated serially: the
// COMPLEMENTO chain carries the "+1" of ~B + 1 from LSB upward.
module CircuitoSomador (
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic COMPLEMENTOin,
  input  logic select,
  output logic R,
  output logic Cout,
  output logic COMPLEMENTOout
);

  logic b_eff;

  always_comb begin
    b_eff          = select ? (~B ^ COMPLEMENTOin) : B;
    COMPLEMENTOout = ~B & COMPLEMENTOin;
    R              = A ^ b_eff ^ Cin;
    Cout           = (A & b_eff) | (A & Cin) | (b_eff & Cin);
  end

endmodule

// File: rtl/controlador_somador_serial.sv
// Bit-serial add/subtract sequencer driving one CircuitoSomador slice LSB-first.
// Optional zero flag output enabled by SOMADOR_SERIAL_ZERO_FLAG_EN.
module controlador_somador_serial
  import somador_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
  output logic             zero,
`endif
  output estado_t          dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  estado_t          estado, estado_prox;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             sub_q, carry_q, comp_q;
  logic             r_bit, cout, comp_out;
  logic             accept, last_bit;
  logic [WIDTH-1:0] res_final;
  logic             ovf_final;

  CircuitoSomador u_slice (
    .A              (a_sh[0]),
    .B              (b_sh[0]),
    .Cin            (carry_q),
    .COMPLEMENTOin  (comp_q),
    .select         (sub_q),
    .R              (r_bit),
    .Cout           (cout),
    .COMPLEMENTOout (comp_out)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) begin
          accept      = 1'b1;
          estado_prox = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_bit) estado_prox = FIM;
      end
      FIM: begin
        done = 1'b1;
        if (start) begin
          accept      = 1'b1;
          estado_prox = CALC;
        end else begin
          estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // On the last bit a_sh[0]/b_sh[0] still hold the original operand MSBs.
  always_comb begin
    last_bit  = (cnt == CW'(WIDTH - 1));
    res_final = {r_bit, res_sh[WIDTH-1:1]};
    if (sub_q) ovf_final = (a_sh[0] != b_sh[0]) && (r_bit != a_sh[0]);
    else       ovf_final = (a_sh[0] == b_sh[0]) && (r_bit != a_sh[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry_q  <= CARRY_RST;
      comp_q   <= COMP_RST;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      sub_q    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      carry_q <= CARRY_RST;
      comp_q  <= COMP_RST;
      a_sh    <= op_a;
      b_sh    <= op_b;
      sub_q   <= sub;
    end else if (estado == CALC) begin
      cnt     <= cnt + CW'(1);
      carry_q <= cout;
      comp_q  <= comp_out;
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh  <= res_final;
      if (last_bit) begin
        result   <= res_final;
        overflow <= ovf_final;
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        zero     <= (res_final == '0);
`endif
      end
    end
  end

  assign dbg_state = estado;

endmodule

// File: tb/tb_controlador_somador_serial.sv
// Directed bench for controlador_somador_serial at WIDTH=3 (zero flag checked
// when SOMADOR_SERIAL_ZERO_FLAG_EN is defined).
module tb_controlador_somador_serial;
  import somador_serial_pkg::*;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, overflow;
  logic [W-1:0] result;
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
  logic         zero;
`endif
  estado_t      dbg_state;

  int total = 0;
  int bad   = 0;

  controlador_somador_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Signed reference: operands as integers in -4..3, overflow when out of range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic ovf);
    int sa, sb, t;
    sa  = a[W-1] ? int'(a) - 8 : int'(a);
    sb  = b[W-1] ? int'(b) - 8 : int'(b);
    t   = s ? sa - sb : sa + sb;
    r   = t[W-1:0];
    ovf = (t > 3) || (t < -4);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    tick();
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
  endtask

  // Waits (bounded) for done; checks busy during CALC, latency and results.
  task automatic finish_op(input string tag, input logic [W-1:0] er, input logic eo);
    int lat;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (busy !== 1'b1) check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(er == '0));
`endif
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    logic [W-1:0] er;
    logic         eo;
    model(a, b, s, er, eo);
    issue(a, b, s);
    finish_op(tag, er, eo);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         eo;
    rst   = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    op_a  = 3'b011;
    op_b  = 3'b001;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(OCIOSO));
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // 3 + (-2) = 1
    issue(3'b011, 3'b110, 1'b0);
    check("add_state", 32'(dbg_state), 32'(CALC));
    finish_op("add", 3'b001, 1'b0);
    tick();
    check("fim_to_idle", 32'(dbg_state), 32'(OCIOSO));

    // 0 - (-4) wraps to -4 with overflow; 2 - 3 = -1
    do_op("sub_ovf", 3'b000, 3'b100, 1'b1);
    check("sub_ovf_hand", 32'(result), 32'd4);
    tick();
    do_op("sub_neg", 3'b010, 3'b011, 1'b1);
    check("sub_neg_hand", 32'(result), 32'd7);
    tick();

    // start held high through CALC with a different op_a is ignored
    issue(3'b001, 3'b001, 1'b0);
    start = 1'b1;
    op_a  = 3'b111;
    sub   = 1'b1;
    tick();
    tick();
    check("hold_busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    check("hold_done", 32'(done), 32'd1);
    check("hold_result", 32'(result), 32'd2);
    check("hold_ovf", 32'(overflow), 32'd0);

    // start in the FIM cycle: accepted back-to-back, 3 + 3 overflows to -2
    do_op("b2b", 3'b011, 3'b011, 1'b0);
    check("b2b_hand", 32'(result), 32'd6);

    // reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(3'b011, 3'b010, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(OCIOSO));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0) check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_result", 32'(result), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);

    // every operand pair, both operations, back-to-back
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          model(3'(a), 3'(b), 1'(s), er, eo);
          issue(3'(a), 3'(b), 1'(s));
          finish_op($sformatf("ex_s%0d_a%0d_b%0d", s, a, b), er, eo);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
